// File: rtl/spi_mult_sequencer.sv
// spi_mult_sequencer
// Pairs consecutive received words into operands A and B and multiplies them
// with an iterative shift-add core, one multiplier bit per cycle. The product
// is streamed out as two words, high word first, on a valid/ready interface.
//
// Build option: define MULT_SIGNED_EN for two's-complement operands (the core
// multiplies magnitudes; the product is negated on load when signs differ).
//
// Ports:
//   clk       clock
//   reset     asynchronous active-low reset
//   rx_valid  one-cycle strobe, rx_data holds a received word
//   rx_data   received word
//   tx_ready  downstream accepts tx_data this cycle
//   tx_valid  tx_data holds a product word
//   tx_data   product word (high, then low); 0 when tx_valid is low
//   busy      high while multiplying or sending
//   overrun   sticky; set when an rx_valid strobe is dropped
module spi_mult_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = PW + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    MULT    = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH:0]   upper_sum;
  logic             tx_valid_d, busy_d, overrun_d;
  logic [WIDTH-1:0] tx_data_d;

`ifdef MULT_SIGNED_EN
  logic neg_a_q, neg_a_d;
  logic neg_q, neg_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_a_q  <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      busy     <= busy_d;
      overrun  <= overrun_d;
`ifdef MULT_SIGNED_EN
      neg_a_q  <= neg_a_d;
      neg_q    <= neg_d;
`endif
    end
  end

  // Upper half of the accumulator plus the multiplicand when the current
  // multiplier bit (acc LSB) is set; W+1 bits hold the carry.
  always_comb begin
    upper_sum = acc_q[AW-1:WIDTH];
    if (acc_q[0]) begin
      upper_sum = acc_q[AW-1:WIDTH] + (WIDTH+1)'(op_a_q);
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    overrun_d = overrun;
`ifdef MULT_SIGNED_EN
    neg_a_d   = neg_a_q;
    neg_d     = neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
`ifdef MULT_SIGNED_EN
          op_a_d  = magnitude(rx_data);
          neg_a_d = rx_data[WIDTH-1];
`else
          op_a_d  = rx_data;
`endif
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        // Multiplier sits in the low half and is consumed LSB first.
        if (rx_valid) begin
`ifdef MULT_SIGNED_EN
          acc_d = {{(WIDTH+1){1'b0}}, magnitude(rx_data)};
          neg_d = neg_a_q ^ rx_data[WIDTH-1];
`else
          acc_d = {{(WIDTH+1){1'b0}}, rx_data};
`endif
          cnt_d   = '0;
          state_d = MULT;
        end
      end
      MULT: begin
        if (cnt_q == CW'(WIDTH)) begin
`ifdef MULT_SIGNED_EN
          prod_d = neg_q ? (~acc_q[PW-1:0] + PW'(1)) : acc_q[PW-1:0];
`else
          prod_d = acc_q[PW-1:0];
`endif
          state_d = SEND_HI;
        end else begin
          acc_d = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND_HI: begin
        if (tx_ready) state_d = SEND_LO;
      end
      SEND_LO: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes arriving while the core is occupied are lost.
    if (rx_valid && (state_q == MULT || state_q == SEND_HI || state_q == SEND_LO)) begin
      overrun_d = 1'b1;
    end

    busy_d     = (state_d == MULT) || (state_d == SEND_HI) || (state_d == SEND_LO);
    tx_valid_d = (state_d == SEND_HI) || (state_d == SEND_LO);
    tx_data_d  = '0;
    if (state_d == SEND_HI) begin
      tx_data_d = prod_d[PW-1:WIDTH];
    end else if (state_d == SEND_LO) begin
      tx_data_d = prod_d[WIDTH-1:0];
    end
  end

endmodule
